// File: rtl/md_unit_iter_if.sv
// Issue/result bundle between the EX-stage control and the HI/LO multiply/divide unit.
// The master issues operations; the unit (slave) drives the status and HI/LO outputs.
interface md_unit_iter_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             cancel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, src_a, src_b, cancel,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, cancel,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/md_unit_iter.sv
// HI/LO multiply/divide unit: fixed-latency multiply with accumulate modes and a
// one-bit-per-cycle restoring divider; mthi/mtlo write HI/LO directly.
module md_unit_iter #(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int CNT_W    = 6
) (
   input  logic         clk,
   input  logic         reset,
   md_unit_iter_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;
   typedef enum logic [1:0] {ACC_LOAD, ACC_ADD, ACC_SUB} acc_e;

   localparam logic [3:0] OP_MULT  = 4'd0, OP_MULTU = 4'd1, OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3, OP_MADD  = 4'd4, OP_MADDU = 4'd5;
   localparam logic [3:0] OP_MSUB  = 4'd6, OP_MSUBU = 4'd7, OP_MTHI  = 4'd8;
   localparam logic [3:0] OP_MTLO  = 4'd9;

   state_e                    state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [WIDTH-1:0]          hi_q, lo_q;
   logic                      busy_q, done_q;
   logic signed [2*WIDTH-1:0] prod_q;
   acc_e                      acc_q;
   logic [WIDTH-1:0]          rem_q, quo_q, dvs_q;
   logic                      qneg_q, rneg_q, dz_q;

   // Two's-complement negate when the result sign must be flipped back.
   function automatic logic [WIDTH-1:0] fix_sign(input logic neg, input logic [WIDTH-1:0] v);
      return neg ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [WIDTH-1:0] abs_val(input logic sgn, input logic [WIDTH-1:0] v);
      return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

   logic                      issue, is_mul, is_div, mul_sgn, div_sgn;
   acc_e                      acc_d;
   logic signed [2*WIDTH-1:0] ma, mb, prod_d, mul_res;
   logic [WIDTH:0]            trial;
   logic [WIDTH-1:0]          diff, rem_d, quo_d;
   logic                      ge;

   always_comb begin
      issue   = bus.start && !bus.cancel && !busy_q;
      is_mul  = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                ((bus.op >= OP_MADD) && (bus.op <= OP_MSUBU));
      is_div  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
      mul_sgn = (bus.op == OP_MULT) || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
      div_sgn = (bus.op == OP_DIV);
      acc_d   = ACC_LOAD;
      if ((bus.op == OP_MADD) || (bus.op == OP_MADDU)) acc_d = ACC_ADD;
      if ((bus.op == OP_MSUB) || (bus.op == OP_MSUBU)) acc_d = ACC_SUB;

      // Sign/zero-extend to full product width; the low 2*WIDTH bits are exact either way.
      ma      = {{WIDTH{mul_sgn & bus.src_a[WIDTH-1]}}, bus.src_a};
      mb      = {{WIDTH{mul_sgn & bus.src_b[WIDTH-1]}}, bus.src_b};
      prod_d  = ma * mb;

      case (acc_q)
         ACC_ADD: mul_res = $signed({hi_q, lo_q}) + prod_q;
         ACC_SUB: mul_res = $signed({hi_q, lo_q}) - prod_q;
         default: mul_res = prod_q;
      endcase

      // Restoring step: the partial remainder always fits WIDTH bits, even for a zero divisor.
      trial = {rem_q, quo_q[WIDTH-1]};
      ge    = (trial >= {1'b0, dvs_q});
      diff  = trial[WIDTH-1:0] - dvs_q;
      rem_d = ge ? diff : trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (issue && is_mul) begin
                  prod_q  <= prod_d;
                  acc_q   <= acc_d;
                  cnt_q   <= CNT_W'(MULT_LAT - 1);
                  busy_q  <= 1'b1;
                  state_q <= S_MUL;
               end else if (issue && is_div) begin
                  quo_q   <= abs_val(div_sgn, bus.src_a);
                  dvs_q   <= abs_val(div_sgn, bus.src_b);
                  rem_q   <= '0;
                  qneg_q  <= div_sgn & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
                  rneg_q  <= div_sgn & bus.src_a[WIDTH-1];
                  dz_q    <= (bus.src_b == '0);
                  cnt_q   <= CNT_W'(WIDTH - 1);
                  busy_q  <= 1'b1;
                  state_q <= S_DIV;
               end else if (issue && (bus.op == OP_MTHI)) begin
                  hi_q <= bus.src_a;
               end else if (issue && (bus.op == OP_MTLO)) begin
                  lo_q <= bus.src_a;
               end
            end
            S_MUL: begin
               if (cnt_q == '0) begin
                  {hi_q, lo_q} <= mul_res;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
                  state_q      <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_DIV: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               if (cnt_q == '0) begin
                  // A zero divisor leaves the remainder equal to |a|, so the fix-up restores a.
                  lo_q    <= dz_q ? '1 : fix_sign(qneg_q, quo_d);
                  hi_q    <= fix_sign(rneg_q, rem_d);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_md_unit_iter.sv
// Directed bench for md_unit_iter (WIDTH=32, MULT_LAT=5): expected values worked out by hand.
module tb_md_unit_iter;
   logic clk = 1'b0;
   logic reset;
   int   cmp = 0;
   int   err = 0;

   md_unit_iter_if #(.WIDTH(32)) bus ();
   md_unit_iter #(.WIDTH(32), .MULT_LAT(5), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: sim time exceeded, required completion");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic c);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.cancel = c;
      @(posedge clk);
      #1 bus.start = 1'b0; bus.cancel = 1'b0;
   endtask

   task automatic window(input int n, output int nb, output int nd);
      nb = 0; nd = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus.busy) nb++;
         if (bus.done) nd++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.start = 1'b0; bus.op = 4'd0; bus.src_a = '0; bus.src_b = '0; bus.cancel = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      cmp++; if (bus.busy !== 1'b0) begin err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      cmp++; if (bus.done !== 1'b0) begin err++; $display("FAIL rst_done: got %b want 0", bus.done); end
      cmp++; if (bus.hi !== 32'h0) begin err++; $display("FAIL rst_hi: got %h want 0", bus.hi); end
      cmp++; if (bus.lo !== 32'h0) begin err++; $display("FAIL rst_lo: got %h want 0", bus.lo); end
   endtask

   task automatic test_mult;
      int nb, nd;
      issue(4'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
      window(10, nb, nd);
      cmp++; if (nb !== 5) begin err++; $display("FAIL mult_busy: got %0d want 5", nb); end
      cmp++; if (nd !== 1) begin err++; $display("FAIL mult_done: got %0d want 1", nd); end
      cmp++; if (bus.hi !== 32'hFFFFFFFF) begin err++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
      cmp++; if (bus.lo !== 32'hFFFFFFFA) begin err++; $display("FAIL mult_lo: got %h want fffffffa", bus.lo); end
      issue(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      window(10, nb, nd);
      cmp++; if (bus.hi !== 32'hFFFFFFFE) begin err++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi); end
      cmp++; if (bus.lo !== 32'h00000001) begin err++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end
   endtask

   task automatic test_div;
      int nb, nd;
      issue(4'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
      window(40, nb, nd);
      cmp++; if (nb !== 32) begin err++; $display("FAIL div_busy: got %0d want 32", nb); end
      cmp++; if (nd !== 1) begin err++; $display("FAIL div_done: got %0d want 1", nd); end
      cmp++; if (bus.lo !== 32'hFFFFFFFD) begin err++; $display("FAIL div_lo: got %h want fffffffd", bus.lo); end
      cmp++; if (bus.hi !== 32'hFFFFFFFF) begin err++; $display("FAIL div_hi: got %h want ffffffff", bus.hi); end
      issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
      window(40, nb, nd);
      cmp++; if (bus.lo !== 32'h7FFFFFFC) begin err++; $display("FAIL divu_lo: got %h want 7ffffffc", bus.lo); end
      cmp++; if (bus.hi !== 32'h00000001) begin err++; $display("FAIL divu_hi: got %h want 00000001", bus.hi); end
   endtask

   task automatic test_accumulate;
      int nb, nd;
      issue(4'd8, 32'h12345678, 32'h0, 1'b0);
      @(negedge clk);
      cmp++; if (bus.hi !== 32'h12345678) begin err++; $display("FAIL mthi_hi: got %h want 12345678", bus.hi); end
      cmp++; if (bus.busy !== 1'b0) begin err++; $display("FAIL mthi_busy: got %b want 0", bus.busy); end
      issue(4'd9, 32'h1, 32'h0, 1'b0);
      @(negedge clk);
      cmp++; if (bus.lo !== 32'h1) begin err++; $display("FAIL mtlo_lo: got %h want 00000001", bus.lo); end
      cmp++; if (bus.done !== 1'b0) begin err++; $display("FAIL mtlo_done: got %b want 0", bus.done); end
      issue(4'd5, 32'hFFFFFFFF, 32'd2, 1'b0);
      window(10, nb, nd);
      cmp++; if (nb !== 5) begin err++; $display("FAIL maddu_busy: got %0d want 5", nb); end
      cmp++; if (bus.hi !== 32'h12345679) begin err++; $display("FAIL maddu_hi: got %h want 12345679", bus.hi); end
      cmp++; if (bus.lo !== 32'hFFFFFFFF) begin err++; $display("FAIL maddu_lo: got %h want ffffffff", bus.lo); end
      // signed product -1 subtracted from HI/LO carries into HI
      issue(4'd6, 32'hFFFFFFFF, 32'd1, 1'b0);
      window(10, nb, nd);
      cmp++; if (bus.hi !== 32'h1234567A) begin err++; $display("FAIL msub_hi: got %h want 1234567a", bus.hi); end
      cmp++; if (bus.lo !== 32'h00000000) begin err++; $display("FAIL msub_lo: got %h want 00000000", bus.lo); end
   endtask

   task automatic test_div_edge;
      int nb, nd;
      issue(4'd3, 32'h55, 32'h0, 1'b0);
      window(40, nb, nd);
      cmp++; if (nb !== 32) begin err++; $display("FAIL divz_busy: got %0d want 32", nb); end
      cmp++; if (bus.lo !== 32'hFFFFFFFF) begin err++; $display("FAIL divz_lo: got %h want ffffffff", bus.lo); end
      cmp++; if (bus.hi !== 32'h55) begin err++; $display("FAIL divz_hi: got %h want 00000055", bus.hi); end
      issue(4'd2, 32'hFFFFFF00, 32'h0, 1'b0);
      window(40, nb, nd);
      cmp++; if (bus.lo !== 32'hFFFFFFFF) begin err++; $display("FAIL sdivz_lo: got %h want ffffffff", bus.lo); end
      cmp++; if (bus.hi !== 32'hFFFFFF00) begin err++; $display("FAIL sdivz_hi: got %h want ffffff00", bus.hi); end
      issue(4'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      window(40, nb, nd);
      cmp++; if (bus.lo !== 32'h80000000) begin err++; $display("FAIL minneg_lo: got %h want 80000000", bus.lo); end
      cmp++; if (bus.hi !== 32'h0) begin err++; $display("FAIL minneg_hi: got %h want 00000000", bus.hi); end
   endtask

   task automatic test_cancel;
      int nb, nd;
      issue(4'd0, 32'd9, 32'd9, 1'b1);
      window(8, nb, nd);
      cmp++; if (nb !== 0) begin err++; $display("FAIL cancel_mult_busy: got %0d want 0", nb); end
      cmp++; if (bus.lo !== 32'h80000000) begin err++; $display("FAIL cancel_mult_lo: got %h want 80000000", bus.lo); end
      issue(4'd9, 32'h1111, 32'h0, 1'b1);
      window(2, nb, nd);
      cmp++; if (bus.lo !== 32'h80000000) begin err++; $display("FAIL cancel_mtlo_lo: got %h want 80000000", bus.lo); end
      cmp++; if (bus.hi !== 32'h0) begin err++; $display("FAIL cancel_mtlo_hi: got %h want 00000000", bus.hi); end
      // cancel while a divide is in flight must not disturb it
      issue(4'd3, 32'd100, 32'd7, 1'b0);
      window(5, nb, nd);
      bus.cancel = 1'b1;
      begin
         int nb2, nd2;
         window(35, nb2, nd2);
         nb += nb2; nd += nd2;
      end
      bus.cancel = 1'b0;
      cmp++; if (nb !== 32) begin err++; $display("FAIL cancel_div_busy: got %0d want 32", nb); end
      cmp++; if (nd !== 1) begin err++; $display("FAIL cancel_div_done: got %0d want 1", nd); end
      cmp++; if (bus.lo !== 32'd14) begin err++; $display("FAIL cancel_div_lo: got %h want 0000000e", bus.lo); end
      cmp++; if (bus.hi !== 32'd2) begin err++; $display("FAIL cancel_div_hi: got %h want 00000002", bus.hi); end
   endtask

   task automatic test_busy_ignore;
      int nb, nd, first;
      issue(4'd0, 32'd3, 32'd4, 1'b0);
      @(negedge clk);
      first = bus.busy ? 1 : 0;
      bus.start = 1'b1; bus.op = 4'd0; bus.src_a = 32'd7; bus.src_b = 32'd99;
      @(posedge clk);
      #1 bus.start = 1'b0;
      window(10, nb, nd);
      nb += first;
      cmp++; if (nb !== 5) begin err++; $display("FAIL ignore_busy: got %0d want 5", nb); end
      cmp++; if (nd !== 1) begin err++; $display("FAIL ignore_done: got %0d want 1", nd); end
      cmp++; if (bus.lo !== 32'd12) begin err++; $display("FAIL ignore_lo: got %h want 0000000c", bus.lo); end
      cmp++; if (bus.hi !== 32'd0) begin err++; $display("FAIL ignore_hi: got %h want 00000000", bus.hi); end
   endtask

   task automatic test_back_to_back;
      int nb, nd;
      bit found = 1'b0;
      issue(4'd0, 32'd2, 32'd3, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done) begin found = 1'b1; break; end
      end
      cmp++;
      if (!found) begin
         err++; $display("FAIL b2b_wait: done not seen in 20 cycles, required a pulse");
      end else begin
         cmp++; if (bus.lo !== 32'd6) begin err++; $display("FAIL b2b_first_lo: got %h want 00000006", bus.lo); end
         bus.start = 1'b1; bus.op = 4'd1; bus.src_a = 32'd5; bus.src_b = 32'd5;
         @(posedge clk);
         #1 bus.start = 1'b0;
         window(10, nb, nd);
         cmp++; if (nb !== 5) begin err++; $display("FAIL b2b_busy: got %0d want 5", nb); end
         cmp++; if (bus.lo !== 32'd25) begin err++; $display("FAIL b2b_lo: got %h want 00000019", bus.lo); end
      end
   endtask

   task automatic test_reset_mid_div;
      int nb, nd;
      issue(4'd2, 32'd100, 32'd3, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      cmp++; if (bus.busy !== 1'b0) begin err++; $display("FAIL rstdiv_busy: got %b want 0", bus.busy); end
      cmp++; if (bus.hi !== 32'h0) begin err++; $display("FAIL rstdiv_hi: got %h want 0", bus.hi); end
      cmp++; if (bus.lo !== 32'h0) begin err++; $display("FAIL rstdiv_lo: got %h want 0", bus.lo); end
      window(40, nb, nd);
      cmp++; if (nd !== 0) begin err++; $display("FAIL rstdiv_done: got %0d want 0", nd); end
      cmp++; if (nb !== 0) begin err++; $display("FAIL rstdiv_busy_after: got %0d want 0", nb); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_accumulate();
      test_div_edge();
      test_cancel();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_div();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end
endmodule
